seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Display-side consumer of the game modes' 20-bit seg_data bus (four 5-bit character codes).
//  Time-multiplexes the four codes onto a common-anode 4-digit 7-segment display.
//  Provides per-digit ghost blanking, frame-atomic snapshotting of seg_data, and per-digit blink.
//  Sits at top level between the mode mux and the board pins.
// PARAMETERS
//  REFRESH_DIV  100_000     clk cycles per digit slot (1 kHz/digit at 100 MHz); >= BLANK_CYC+2
//  BLANK_CYC    1_000       cycles at slot start with all anodes off (anti-ghost)
//  BLINK_DIV    50_000_000  cycles per blink phase toggle (0.5 s on / 0.5 s off)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  seg_data     in   20  {d3,d2,d1,d0} 5-bit char codes; d3=[19:15] is leftmost digit
//  blink_mask   in   4   bit k=1: digit k blanked during blink-off phase
//  dp_mask      in   4   bit k=1: decimal point of digit k lit
//  seg          out  7   segments {g,f,e,d,c,b,a}, active low
//  dp           out  1   decimal point, active low
//  an           out  4   anodes, active low; an[3] = leftmost digit
//  frame_start  out  1   1-cycle pulse when a new seg_data snapshot is taken
// BEHAVIOUR
//  - Single clock domain; reset is synchronous and active-high. All outputs are registered.
//  - Reset values:
//      an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
//      Snapshot = all C_BLANK; digit_idx=0; slot_cnt=0; blink_cnt=0; blink_on=1.
//  - Counters:
//      slot_cnt counts 0..REFRESH_DIV-1. On wrap, digit_idx increments 0->1->2->3->0.
//      blink_cnt counts 0..BLINK_DIV-1. On wrap, blink_on toggles. blink_cnt is free-running
//      and independent of the scan.
//  - Snapshot:
//      In the cycle where digit_idx==0 and slot_cnt==0, seg_data, blink_mask and dp_mask are
//      copied into shadow registers, and frame_start is asserted the next cycle.
//      Mid-frame changes to the inputs are never displayed until the next frame (no tearing).
//  - Latency: outputs are registered functions of (digit_idx, slot_cnt, shadow, blink_on)
//    from the previous cycle, i.e. one cycle of latency.
//  - Slot output:
//      slot_cnt < BLANK_CYC: an=4'b1111, seg=7'h7F, dp=1.
//      Otherwise: an = ~(1<<digit_idx); seg = ROM(shadow code k); dp = ~shadow_dp[k].
//      If shadow_blink[k] && !blink_on: an[k] stays 1 (digit dark), seg=7'h7F, dp=1.
//  - Character ROM (seg, active low):
//      0-9 = digits (code 9 also serves as 'g'); 10 A; 11 b; 12 C; 13 E; 14 F; 15 U; 16 P;
//      17 o; 18 L; 19 d; 20 n; 21 r; 22 H; 23 t; 24-30 '-' (g only); 31 blank (7'h7F).
//      Examples: '0'=7'b1000000, '1'=7'b1111001, 'U'=7'b1000001, 'P'=7'b0001100,
//      '-'=7'b0111111.
//  - At most one anode is low in any cycle. Every digit gets an identical lit time of
//    REFRESH_DIV-BLANK_CYC cycles per frame.
//  - Reset asserted mid-slot: on the next edge all outputs return to reset values and the
//    scan restarts at digit 0 with a fresh snapshot.
// STRUCTURE
//  - Shared package/header: the 5-bit char code localparams (C_BLANK=31, C_U=15, C_P=16,
//    C_o=17, C_d=19, C_n=20, C_g=9, ...). The game modes use the same definitions.
//  - Sub-module seg7_char_rom: combinational 5-bit code -> 7-bit active-low pattern.
//  - Scan counters, shadow registers, blink logic and output registers live in the top.
// TESTING (bench params: REFRESH_DIV=4, BLANK_CYC=1, BLINK_DIV=64)
//  1. Reset held 3 cycles -> an=1111, seg=7F, dp=1 throughout. After release, first frame
//     shows all digits dark (blank snapshot until first load), frame_start pulses.
//  2. seg_data={31,31,0,5} ("  05") -> each frame: an=1110 with seg='5', an=1101 with
//     seg='0', 3 cycles lit each. Slots 2-3 show seg=7F. Never two anodes low at once.
//  3. seg_data={1,2,15,16} ("12UP") -> an[1]/an[0] slots show 'U'=7'b1000001 and
//     'P'=7'b0001100. Change seg_data mid-frame to {9,17,17,19} -> old value held to end of
//     frame, then "good" appears; frame_start coincides with the new snapshot.
//  4. blink_mask=4'b0001 -> digit 0 lit for 64 cycles and dark for 64 cycles, alternating;
//     digits 1-3 are unaffected.
//  5. dp_mask=4'b0100 -> dp=0 only during the lit part of the an=1011 slot; dp=1 elsewhere.
//  6. Reset pulse asserted at digit_idx=2, slot_cnt=2 -> next cycle outputs at reset values;
//     scan restarts at digit 0 and the snapshot reloads.

Source files
------------

// File: rtl/seg7_scan_display_pkg.sv
// Shared character-code definitions for the 4-digit 7-segment display path.
// The game modes build their 20-bit seg_data bus from these same codes, so the
// display and its producers always agree on the encoding.
package seg7_scan_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = 5;
    localparam int SEG_W      = 7;

    // 5-bit character codes
    localparam logic [CODE_W-1:0] C_0     = 5'd0;
    localparam logic [CODE_W-1:0] C_1     = 5'd1;
    localparam logic [CODE_W-1:0] C_2     = 5'd2;
    localparam logic [CODE_W-1:0] C_3     = 5'd3;
    localparam logic [CODE_W-1:0] C_4     = 5'd4;
    localparam logic [CODE_W-1:0] C_5     = 5'd5;
    localparam logic [CODE_W-1:0] C_6     = 5'd6;
    localparam logic [CODE_W-1:0] C_7     = 5'd7;
    localparam logic [CODE_W-1:0] C_8     = 5'd8;
    localparam logic [CODE_W-1:0] C_9     = 5'd9;
    localparam logic [CODE_W-1:0] C_g     = 5'd9;   // '9' doubles as 'g'
    localparam logic [CODE_W-1:0] C_A     = 5'd10;
    localparam logic [CODE_W-1:0] C_b     = 5'd11;
    localparam logic [CODE_W-1:0] C_C     = 5'd12;
    localparam logic [CODE_W-1:0] C_E     = 5'd13;
    localparam logic [CODE_W-1:0] C_F     = 5'd14;
    localparam logic [CODE_W-1:0] C_U     = 5'd15;
    localparam logic [CODE_W-1:0] C_P     = 5'd16;
    localparam logic [CODE_W-1:0] C_o     = 5'd17;
    localparam logic [CODE_W-1:0] C_L     = 5'd18;
    localparam logic [CODE_W-1:0] C_d     = 5'd19;
    localparam logic [CODE_W-1:0] C_n     = 5'd20;
    localparam logic [CODE_W-1:0] C_r     = 5'd21;
    localparam logic [CODE_W-1:0] C_H     = 5'd22;
    localparam logic [CODE_W-1:0] C_t     = 5'd23;
    localparam logic [CODE_W-1:0] C_DASH  = 5'd24;  // 24..30 all render '-'
    localparam logic [CODE_W-1:0] C_BLANK = 5'd31;

    // Active-low segment pattern with every segment off
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Four blank characters, used as the snapshot reset value
    localparam logic [NUM_DIGITS*CODE_W-1:0] DATA_BLANK = {NUM_DIGITS{C_BLANK}};

endpackage

// File: rtl/seg7_char_rom.sv
// Combinational character ROM: 5-bit char code -> active-low segment pattern.
// Ports:
//   code    in  5  character code (see seg7_scan_display_pkg)
//   pattern out 7  segments {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_char_rom
    import seg7_scan_display_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  pattern
);

    always_comb begin
        pattern = 7'b0111111;  // codes 24..30: '-'
        case (code)
            C_0:     pattern = 7'b1000000;
            C_1:     pattern = 7'b1111001;
            C_2:     pattern = 7'b0100100;
            C_3:     pattern = 7'b0110000;
            C_4:     pattern = 7'b0011001;
            C_5:     pattern = 7'b0010010;
            C_6:     pattern = 7'b0000010;
            C_7:     pattern = 7'b1111000;
            C_8:     pattern = 7'b0000000;
            C_9:     pattern = 7'b0010000;
            C_A:     pattern = 7'b0001000;
            C_b:     pattern = 7'b0000011;
            C_C:     pattern = 7'b1000110;
            C_E:     pattern = 7'b0000110;
            C_F:     pattern = 7'b0001110;
            C_U:     pattern = 7'b1000001;
            C_P:     pattern = 7'b0001100;
            C_o:     pattern = 7'b0100011;
            C_L:     pattern = 7'b1000111;
            C_d:     pattern = 7'b0100001;
            C_n:     pattern = 7'b0101011;
            C_r:     pattern = 7'b0101111;
            C_H:     pattern = 7'b0001001;
            C_t:     pattern = 7'b0000111;
            C_BLANK: pattern = SEG_OFF;
            default: pattern = 7'b0111111;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display.
// Snapshots seg_data/blink_mask/dp_mask once per frame (no tearing), blanks
// all anodes at the start of every digit slot (anti-ghosting) and blinks
// selected digits from a free-running blink timer.
// Ports:
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   seg_data     in  20   {d3,d2,d1,d0} char codes, d3 leftmost
//   blink_mask   in   4   bit k: digit k dark during blink-off phase
//   dp_mask      in   4   bit k: decimal point of digit k lit
//   seg          out  7   {g,f,e,d,c,b,a}, active low
//   dp           out  1   decimal point, active low
//   an           out  4   anodes, active low, an[3] leftmost
//   frame_start  out  1   one-cycle pulse after a snapshot is taken
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLANK_CYC   = 1_000,
    parameter int BLINK_DIV   = 50_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_DIGITS*CODE_W-1:0]   seg_data,
    input  logic [NUM_DIGITS-1:0]          blink_mask,
    input  logic [NUM_DIGITS-1:0]          dp_mask,
    output logic [SEG_W-1:0]               seg,
    output logic                           dp,
    output logic [NUM_DIGITS-1:0]          an,
    output logic                           frame_start
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

    logic [SLOT_W-1:0]                    slot_cnt;
    logic [1:0]                           digit_idx;
    logic [BLINK_W-1:0]                   blink_cnt;
    logic                                 blink_on;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]    shadow_code;
    logic [NUM_DIGITS-1:0]                shadow_blink;
    logic [NUM_DIGITS-1:0]                shadow_dp;

    logic                                 slot_wrap;
    logic                                 frame_load;
    logic [SEG_W-1:0]                     rom_seg;
    logic [SEG_W-1:0]                     seg_nxt;
    logic                                 dp_nxt;
    logic [NUM_DIGITS-1:0]                an_nxt;

    assign slot_wrap  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    // Snapshot lands during the blank window of slot 0, so the new frame's
    // first lit cycle already sees the fresh shadow.
    assign frame_load = (digit_idx == 2'd0) && (slot_cnt == '0);

    seg7_char_rom u_rom (
        .code    (shadow_code[digit_idx]),
        .pattern (rom_seg)
    );

    // Scan and blink counters
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (slot_wrap) begin
                slot_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                slot_cnt  <= slot_cnt + SLOT_W'(1);
            end
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Frame-atomic shadow of the display inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_code  <= DATA_BLANK;
            shadow_blink <= '0;
            shadow_dp    <= '0;
        end else if (frame_load) begin
            shadow_code  <= seg_data;
            shadow_blink <= blink_mask;
            shadow_dp    <= dp_mask;
        end
    end

    // Next-output decode for the current slot
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (slot_cnt >= SLOT_W'(BLANK_CYC) &&
            !(shadow_blink[digit_idx] && !blink_on)) begin
            an_nxt            = '1;
            an_nxt[digit_idx] = 1'b0;
            seg_nxt           = rom_seg;
            dp_nxt            = ~shadow_dp[digit_idx];
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= frame_load;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with a small slot/blink configuration.
// Reference model: the display timeline is a pure function of the number of
// clock edges since reset release, plus the inputs latched at each frame start.
module tb_seg7_scan_display;

    localparam int R  = 4;   // REFRESH_DIV
    localparam int BC = 1;   // BLANK_CYC
    localparam int BL = 64;  // BLINK_DIV

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] seg_data;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int vectors = 0;
    int errors  = 0;

    // model state
    int          k;        // non-reset edges since reset release
    logic [19:0] m_data;
    logic [3:0]  m_blink;
    logic [3:0]  m_dp;

    always #5 clk = ~clk;

    seg7_scan_display #(.REFRESH_DIV(R), .BLANK_CYC(BC), .BLINK_DIV(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_data    (seg_data),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] glyph(input int c);
        case (c)
            0:  glyph = 7'h40;  1:  glyph = 7'h79;  2:  glyph = 7'h24;
            3:  glyph = 7'h30;  4:  glyph = 7'h19;  5:  glyph = 7'h12;
            6:  glyph = 7'h02;  7:  glyph = 7'h78;  8:  glyph = 7'h00;
            9:  glyph = 7'h10;  10: glyph = 7'h08;  11: glyph = 7'h03;
            12: glyph = 7'h46;  13: glyph = 7'h06;  14: glyph = 7'h0E;
            15: glyph = 7'h41;  16: glyph = 7'h0C;  17: glyph = 7'h23;
            18: glyph = 7'h47;  19: glyph = 7'h21;  20: glyph = 7'h2B;
            21: glyph = 7'h2F;  22: glyph = 7'h09;  23: glyph = 7'h07;
            31: glyph = 7'h7F;
            default: glyph = 7'h3F;
        endcase
    endfunction

    function automatic logic [19:0] pack4(input int d3, input int d2, input int d1, input int d0);
        logic [4:0] a, b, c, d;
        a = d3[4:0]; b = d2[4:0]; c = d1[4:0]; d = d0[4:0];
        return {a, b, c, d};
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        vectors++;
        assert (got === want) else begin
            errors++;
            $display("FAIL %s at k=%0d: observed %h expected %h", tag, k, got, want);
            $error("miscompare on %s", tag);
        end
    endtask

    // One clock: predict from model + current inputs, clock, then compare.
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fs;
        int slot, dig;
        bit bon;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        if (reset) begin
            k = 0; m_data = 20'hFFFFF; m_blink = 4'h0; m_dp = 4'h0;
        end else begin
            slot = k % R;
            dig  = (k / R) % 4;
            bon  = ((k / BL) % 2) == 0;
            e_fs = (slot == 0) && (dig == 0);
            if (slot >= BC && !(m_blink[dig] && !bon)) begin
                e_an[dig] = 1'b0;
                e_seg     = glyph(int'(m_data[dig*5 +: 5]));
                e_dp      = ~m_dp[dig];
            end
            if (e_fs) begin
                m_data = seg_data; m_blink = blink_mask; m_dp = dp_mask;
            end
            k++;
        end
        @(posedge clk);
        #1;
        chk("an", {3'b0, an}, {3'b0, e_an});
        chk("seg", seg, e_seg);
        chk("dp", {6'b0, dp}, {6'b0, e_dp});
        chk("frame_start", {6'b0, frame_start}, {6'b0, e_fs});
        chk("one_anode", ($countones(~an) <= 1) ? 7'd1 : 7'd0, 7'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        k = 0; m_data = 20'hFFFFF; m_blink = 4'h0; m_dp = 4'h0;
        reset = 1'b1;
        seg_data = 20'hFFFFF; blink_mask = 4'h0; dp_mask = 4'h0;
        @(negedge clk);

        // 1: reset held, then first (blank) frame
        run(3);
        reset = 1'b0;
        run(16);

        // 2: "  05"
        seg_data = pack4(31, 31, 0, 5);
        run(32);

        // 3: "12UP", then "good" mid-frame
        seg_data = pack4(1, 2, 15, 16);
        run(22);
        seg_data = pack4(9, 17, 17, 19);
        run(26);

        // 4: blink digit 0
        blink_mask = 4'b0001;
        run(160);
        blink_mask = 4'b0000;

        // 5: decimal point on digit 2
        dp_mask = 4'b0100;
        run(32);
        dp_mask = 4'b0000;

        // 6: reset at digit 2, slot 2
        while ((k % (4 * R)) != (2 * R + 2)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seg_data = pack4(22, 13, 18, 0);
        run(20);

        // 7: randomized inputs and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)  seg_data   = 20'($urandom);
            if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 19) == 0) dp_mask    = 4'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        run(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
